// File: rtl/serial_add_datapath.sv
// Bit-serial adder datapath: decodes the external FSM state to load operands,
// add one bit per clock LSB-first, and hold the result; owns the bit counter.
module serial_add_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       STATE,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             counterflag,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sum_valid
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ADD  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t           state_dec;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             sv_q;
  logic             s_bit, c_next;

  assign state_dec = state_t'(STATE);

  // Full adder on the current LSBs; only consumed while ADD is unsaturated.
  assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  assign counterflag = (cnt_q == CNT_MAX);
  assign sum         = s_q;
  assign cout        = c_q;
  assign sum_valid   = sv_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      sv_q  <= 1'b0;
    end else begin
      case (state_dec)
        ST_IDLE: begin
          cnt_q <= '0;
          sv_q  <= 1'b0;
        end
        ST_LOAD: begin
          a_q   <= a_in;
          b_q   <= b_in;
          c_q   <= cin;
          s_q   <= '0;
          cnt_q <= '0;
          sv_q  <= 1'b0;
        end
        ST_ADD: begin
          sv_q <= 1'b0;
          // Once WIDTH bits are in, further ADD cycles leave the result untouched.
          if (!counterflag) begin
            c_q   <= c_next;
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            s_q   <= {s_bit, s_q[WIDTH-1:1]};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          sv_q <= 1'b1;
        end
        default: begin
          sv_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_datapath.sv
// Self-checking bench for serial_add_datapath: directed cases, reset mid-add,
// a WIDTH=4 instance, and random FSM-driven operations against A+B+cin.
module tb_serial_add_datapath;

  logic       clk;
  logic       rst;
  // WIDTH=8 instance signals
  logic [1:0] state8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       cf8, cout8, sv8;
  logic [7:0] sum8;
  // WIDTH=4 instance signals
  logic [1:0] state4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       cf4, cout4, sv4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  serial_add_datapath #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .STATE(state8), .a_in(a8), .b_in(b8), .cin(cin8),
    .counterflag(cf8), .sum(sum8), .cout(cout8), .sum_valid(sv8)
  );

  serial_add_datapath #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .STATE(state4), .a_in(a4), .b_in(b4), .cin(cin4),
    .counterflag(cf4), .sum(sum4), .cout(cout4), .sum_valid(sv4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full operation on the 8-bit instance: LOAD, ADD until counterflag, DONE, IDLE.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n;
    logic [8:0] exp;
    state8 = 2'b01; a8 = a; b8 = b; cin8 = c;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    tick();
    state8 = 2'b10;
    n = 0;
    while (!cf8 && n < 20) begin
      tick();
      n++;
    end
    check("add_cycles", n, 8);
    state8 = 2'b11;
    check("sv_before_done_edge", sv8, 1'b0);
    tick();
    check("sum_valid", sv8, 1'b1);
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check("result", {cout8, sum8}, exp);
    end
    state8 = 2'b00;
    tick();
    check("sv_idle", sv8, 1'b0);
    check("sum_held_idle", {cout8, sum8}, exp);
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b0;
    state8 = 2'b00; a8 = '0; b8 = '0; cin8 = 1'b0;
    state4 = 2'b00; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick();
    tick();
    check("rst_sum", sum8, 8'h00);
    check("rst_cout", cout8, 1'b0);
    check("rst_cf", cf8, 1'b0);
    check("rst_sv", sv8, 1'b0);
    rst = 1'b1;

    // ADD without LOAD after reset operates on zeros
    state8 = 2'b10;
    repeat (8) tick();
    check("noload_sum", {cout8, sum8}, 9'h000);
    check("noload_cf", cf8, 1'b1);
    state8 = 2'b00;
    tick();

    // directed results
    run_op8(8'h5A, 8'h3C, 1'b0);
    run_op8(8'hFF, 8'h01, 1'b0);
    run_op8(8'hFF, 8'hFF, 1'b1);

    // counterflag timing and ADD saturation
    state8 = 2'b01; a8 = 8'hA7; b8 = 8'h6E; cin8 = 1'b1;
    tick();
    state8 = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("cf_add%0d", k), cf8, (k == 8) ? 1'b1 : 1'b0);
    end
    check("sat_result", {cout8, sum8}, 9'h116);
    held = sum8;
    repeat (3) tick();
    check("sat_sum", sum8, held);
    check("sat_cout", cout8, 1'b1);
    check("sat_cf", cf8, 1'b1);
    state8 = 2'b00;
    tick();

    // reset mid-ADD
    state8 = 2'b01; a8 = 8'hF3; b8 = 8'h2D; cin8 = 1'b1;
    tick();
    state8 = 2'b10;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    check("midrst_sum", sum8, 8'h00);
    check("midrst_cout", cout8, 1'b0);
    check("midrst_cf", cf8, 1'b0);
    check("midrst_sv", sv8, 1'b0);
    rst = 1'b1;
    state8 = 2'b00;
    tick();
    run_op8(8'h12, 8'h34, 1'b0);

    // WIDTH=4 instance
    state4 = 2'b01; a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0;
    tick();
    state4 = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("w4_cf_add%0d", k), cf4, (k == 4) ? 1'b1 : 1'b0);
    end
    state4 = 2'b11;
    tick();
    check("w4_sum", sum4, 4'h1);
    check("w4_cout", cout4, 1'b1);
    check("w4_sv", sv4, 1'b1);
    state4 = 2'b00;
    tick();

    // random FSM-driven operations
    for (int i = 0; i < 1000; i++) begin
      run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
    end
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
